// File: rtl/inst_trace_buffer.sv
// Instruction commit trace buffer: captures a bounded run of retired PC/instruction
// pairs into a first-word-fall-through FIFO. Define TRACE_CYCLE_STAMP_EN to add out_cycle.
module inst_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int MAX_COUNT = 10000
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_pc,
  input  logic [31:0]              commit_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
`ifdef TRACE_CYCLE_STAMP_EN
  output logic [31:0]              out_cycle,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_COUNT + 1);
  localparam logic [CW-1:0] CAP_LAST = CW'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_e;

  typedef struct packed {
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] cyc;
`endif
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_e          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [CW-1:0]   cap_cnt_q, cap_cnt_d;
  logic [31:0]     cyc_q, cyc_d;
  logic [15:0]     drop_q, drop_d;
  logic            ovf_q, ovf_d;
  logic            pop, push, drop, room, cap;
  entry_t          mem_q [DEPTH];
  entry_t          wr_entry, head;

  always_comb begin
    cap  = (state_q == CAPTURE);
    pop  = (level_q != '0) && out_ready;
    // Full FIFO still accepts when the head leaves on the same edge.
    room = !level_q[AW] || pop;
    push = cap && commit_valid && room;
    drop = cap && commit_valid && !room;

    wr_entry      = '0;
    wr_entry.pc   = commit_pc;
    wr_entry.inst = commit_inst;
`ifdef TRACE_CYCLE_STAMP_EN
    wr_entry.cyc  = cyc_q;
`endif

    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;

    state_d   = state_q;
    cap_cnt_d = cap_cnt_q;
    cyc_d     = cyc_q;
    drop_d    = drop_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = CAPTURE;
          cap_cnt_d = '0;
          cyc_d     = '0;
          drop_d    = '0;
          ovf_d     = 1'b0;
        end
      end
      CAPTURE: begin
        cyc_d = cyc_q + 32'd1;
        if (commit_valid) begin
          cap_cnt_d = cap_cnt_q + 1'b1;
          if (cap_cnt_d == CAP_LAST) state_d = DRAIN;
        end
        if (drop) begin
          ovf_d = 1'b1;
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
      end
      DRAIN: begin
        if (level_d == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= '0;
      cap_cnt_q <= '0;
      cyc_q     <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
      cap_cnt_q <= cap_cnt_d;
      cyc_q     <= cyc_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage is not reset; outputs are gated by occupancy instead.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_valid  = (level_q != '0);
    out_pc     = out_valid ? head.pc   : 32'd0;
    out_inst   = out_valid ? head.inst : 32'd0;
`ifdef TRACE_CYCLE_STAMP_EN
    out_cycle  = out_valid ? head.cyc  : 32'd0;
`endif
    busy       = (state_q == CAPTURE) || (state_q == DRAIN);
    done       = (state_q == DONE);
    overflow   = ovf_q;
    drop_count = drop_q;
    level      = level_q;
  end
endmodule

// File: doc/inst_trace_buffer.md
INST_TRACE_BUFFER -- requirements
Module: inst_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter MAX_COUNT, default 10000, commits captured per run.
REQ-003 SHALL have port clk_in, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, begin a capture run.
REQ-006 SHALL have port commit_valid, input, 1, a CPU instruction retires this cycle.
REQ-007 SHALL have port commit_pc, input, 32, PC of the retiring instruction.
REQ-008 SHALL have port commit_inst, input, 32, encoding of the retiring instruction.
REQ-009 SHALL have port out_valid, output, 1, head entry available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts head entry.
REQ-011 SHALL have ports out_pc and out_inst, output, 32 each, head entry fields.
REQ-012 SHALL have port busy, output, 1, high in CAPTURE or DRAIN.
REQ-013 SHALL have port done, output, 1, high in DONE.
REQ-014 SHALL have port overflow, output, 1, sticky: at least one commit dropped this run.
REQ-015 SHALL have port drop_count, output, 16, dropped commits this run, saturating at 0xFFFF.
REQ-016 SHALL have port level, output, log2(DEPTH)+1, current FIFO occupancy.

Function
REQ-017 SHALL implement FSM with states IDLE, CAPTURE, DRAIN and DONE.
REQ-018 IDLE or DONE with start=1 SHALL go to CAPTURE and clear cap_count, cycle counter, drop_count and overflow; FIFO contents are kept.
REQ-019 start SHALL be ignored in CAPTURE and DRAIN.
REQ-020 In CAPTURE, each commit_valid=1 cycle SHALL increment cap_count; the FSM SHALL go to DRAIN on the edge that accepts or drops commit number MAX_COUNT.
REQ-021 commit_valid SHALL be ignored (not counted, not stored) in IDLE, DRAIN and DONE.
REQ-022 A counted commit SHALL be written if level<DEPTH, or if level==DEPTH with a pop in the same cycle; otherwise it SHALL be dropped, overflow set and drop_count incremented.
REQ-023 DRAIN SHALL go to DONE on the cycle level reaches 0; if entry into DRAIN finds level==0, the transition SHALL occur on the next edge.
REQ-024 out_valid SHALL equal (level!=0); out_pc and out_inst SHALL present the oldest entry combinationally (first-word fall-through).
REQ-025 A pop SHALL occur when out_valid and out_ready are both high, in any state.
REQ-026 A written entry SHALL be visible at the outputs one cycle after the commit (write at edge N, out_valid high after edge N).
REQ-027 Simultaneous push and pop SHALL leave level unchanged; read and write pointers wrap modulo DEPTH.
REQ-028 The cycle counter SHALL increment every cycle in CAPTURE, starting at 0 in the first CAPTURE cycle, and wrap at 2^32.

Reset
REQ-029 On reset low, SHALL immediately enter IDLE with empty FIFO, level=0, out_valid=0, busy=0, done=0, overflow=0, drop_count=0, and all counters at 0; out_pc/out_inst=0.
REQ-030 Reset asserted mid-run SHALL discard all entries and counts without a drain.
REQ-031 Reset release SHALL leave the block in IDLE until start.

Configuration
REQ-032 With macro TRACE_CYCLE_STAMP_EN defined, SHALL add port out_cycle, output, 32, holding the cycle counter value sampled at the commit, stored per entry.
REQ-033 Without TRACE_CYCLE_STAMP_EN, SHALL omit out_cycle and its per-entry storage; all other behaviour is identical.

Verification
REQ-034 Reset, start, 3 commits (pc 0x00400000/4/8), out_ready=1 -> three pops in order with matching pc/inst; level never above 1.
REQ-035 MAX_COUNT=5, out_ready=0, 5 commits -> level=5, busy=1, FSM in DRAIN; raise out_ready -> 5 pops, done=1 on the cycle level reaches 0.
REQ-036 DEPTH=4, out_ready=0, 7 commits -> level=4, overflow=1, drop_count=3; the first 4 pcs retained.
REQ-037 Full FIFO, commit and pop on the same cycle -> level stays 4, no drop, new entry at tail.
REQ-038 Reset pulse mid-CAPTURE with level=3 -> out_valid=0, level=0, IDLE immediately; later commits ignored until start.
REQ-039 TRACE_CYCLE_STAMP_EN defined, commits in CAPTURE cycles 0, 2 and 7 -> out_cycle 0, 2, 7.
